decode_stage_ctrl: RTL and testbench

//  IF/ID pipeline-register controller for the decode stage. Accepts fetched instructions with a

---
 rtl/decode_stage_ctrl_pkg.sv | 24 ++
 rtl/decode_stage_ctrl_ld_use_hazard.sv | 26 ++
 rtl/decode_stage_ctrl.sv | 119 +++++++++++
 tb/tb_decode_stage_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_ctrl_pkg.sv
// Shared decode-stage definitions: instruction/word widths, LEGv8 opcode constants,
// and the decode controller state type.
package decode_stage_ctrl_pkg;

    localparam int unsigned INSTR_LEN = 32;
    localparam int unsigned WORD      = 64;

    localparam logic [10:0] OP_STUR    = 11'h7C0;
    localparam logic [10:0] OP_LDUR    = 11'h7C2;
    localparam logic [6:0]  OP_CBZ_PFX = 7'b1011010;
    localparam logic [4:0]  XZR        = 5'd31;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_STALL
    } dstate_t;

    // STUR and CBZ/CBNZ read the register named in the Rt field [4:0].
    function automatic logic reads_rt(input logic [INSTR_LEN-1:0] instr);
        return (instr[31:21] == OP_STUR) || (instr[31:25] == OP_CBZ_PFX);
    endfunction

endpackage

// File: rtl/decode_stage_ctrl_ld_use_hazard.sv
// Combinational load-use hazard detect: the load in EX writes a register that the
// instruction held in decode reads.
module ld_use_hazard
    import decode_stage_ctrl_pkg::*;
(
    input  logic [INSTR_LEN-1:0] id_instr,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd,
    output logic                 hazard
);

    logic rn_match;
    logic rm_match;
    logic rt_match;
    logic unused_bits;

    assign unused_bits = ^id_instr[15:10];

    always_comb begin
        rn_match = (ex_rd == id_instr[9:5]);
        rm_match = (ex_rd == id_instr[20:16]);
        rt_match = reads_rt(id_instr) && (ex_rd == id_instr[4:0]);
        hazard   = ex_mem_read && (ex_rd != XZR) && (rn_match || rm_match || rt_match);
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// IF/ID pipeline-register controller: valid/ready handshake with fetch and EX,
// load-use bubble insertion, branch flush and a saturating bubble counter.
module decode_stage_ctrl
    import decode_stage_ctrl_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_valid,
    input  logic [INSTR_LEN-1:0] if_instr,
    input  logic [WORD-1:0]      if_pc,
    output logic                 if_ready,
    input  logic                 ex_ready,
    output logic                 id_valid,
    output logic [INSTR_LEN-1:0] id_instr,
    output logic [WORD-1:0]      id_pc,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rd,
    input  logic                 flush,
    output logic [CNT_W-1:0]     stall_count
);

    dstate_t              state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [INSTR_LEN-1:0] instr_n;
    logic [WORD-1:0]      pc_n;
    logic                 hazard;
    logic                 bubble;

    ld_use_hazard u_hazard (
        .id_instr    (id_instr),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .hazard      (hazard)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            cnt         <= '0;
            id_instr    <= '0;
            id_pc       <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            id_instr <= instr_n;
            id_pc    <= pc_n;
            if (bubble && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

    // The hazard cycle in FULL is itself the first bubble, so STALL covers only
    // the remaining STALL_CYCLES-1 bubbles and is skipped entirely for one.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        instr_n  = id_instr;
        pc_n     = id_pc;
        if_ready = 1'b0;
        id_valid = 1'b0;
        bubble   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if_ready = 1'b1;
                if (if_valid) begin
                    instr_n = if_instr;
                    pc_n    = if_pc;
                    state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                if (hazard) begin
                    bubble = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_n = ST_STALL;
                        cnt_n   = 4'(STALL_CYCLES - 1);
                    end
                end else begin
                    id_valid = 1'b1;
                    if (ex_ready) begin
                        if_ready = 1'b1;
                        if (if_valid) begin
                            instr_n = if_instr;
                            pc_n    = if_pc;
                        end else begin
                            instr_n = '0;
                            pc_n    = '0;
                            state_n = ST_EMPTY;
                        end
                    end
                end
            end
            ST_STALL: begin
                bubble = 1'b1;
                if (cnt <= 4'd1)
                    state_n = ST_FULL;
                else
                    cnt_n = cnt - 4'd1;
            end
            default: begin
                state_n = ST_EMPTY;
                instr_n = '0;
                pc_n    = '0;
            end
        endcase
        if (flush) begin
            state_n  = ST_EMPTY;
            instr_n  = '0;
            pc_n     = '0;
            cnt_n    = '0;
            if_ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed table-driven bench for decode_stage_ctrl: default-parameter instance for
// streaming/hazard/backpressure, STALL_CYCLES=3/CNT_W=2 instance for stall length,
// saturation, flush and mid-stall reset.
module tb_decode_stage_ctrl;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        exr;
        logic        memrd;
        logic [4:0]  exrd;
        logic        flush;
        logic        e_ifr;
        logic        e_idv;
        logic        chk_idv;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        int unsigned e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        ex_ready;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        flush;

    logic        ifr1, idv1, ifr3, idv3;
    logic [31:0] ins1, ins3;
    logic [63:0] pc1, pc3;
    logic [15:0] cnt1;
    logic [1:0]  cnt3;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    decode_stage_ctrl u_dut1 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(ifr1), .ex_ready(ex_ready), .id_valid(idv1), .id_instr(ins1), .id_pc(pc1),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush), .stall_count(cnt1)
    );

    decode_stage_ctrl #(.STALL_CYCLES(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_ready(ifr3), .ex_ready(ex_ready), .id_valid(idv3), .id_instr(ins3), .id_pc(pc3),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .flush(flush), .stall_count(cnt3)
    );

    function automatic logic [31:0] rf(input logic [10:0] op, input logic [4:0] rm,
                                       input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic [63:0] pc,
                                input logic exr, input logic memrd, input logic [4:0] exrd,
                                input logic fl, input logic e_ifr, input logic e_idv,
                                input logic [31:0] e_instr, input logic [63:0] e_pc,
                                input int unsigned e_cnt);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.exr = exr; v.memrd = memrd; v.exrd = exrd;
        v.flush = fl; v.e_ifr = e_ifr; v.e_idv = e_idv; v.chk_idv = 1'b1;
        v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic apply(input vec_t v, input bit sel3, input string tag, input int idx);
        if_valid    = v.iv;
        if_instr    = v.instr;
        if_pc       = v.pc;
        ex_ready    = v.exr;
        ex_mem_read = v.memrd;
        ex_rd       = v.exrd;
        flush       = v.flush;
        @(negedge clk);
        chk($sformatf("%s[%0d].if_ready", tag, idx), 64'(sel3 ? ifr3 : ifr1), 64'(v.e_ifr));
        if (v.chk_idv)
            chk($sformatf("%s[%0d].id_valid", tag, idx), 64'(sel3 ? idv3 : idv1), 64'(v.e_idv));
        chk($sformatf("%s[%0d].id_instr", tag, idx), 64'(sel3 ? ins3 : ins1), 64'(v.e_instr));
        chk($sformatf("%s[%0d].id_pc", tag, idx), sel3 ? pc3 : pc1, v.e_pc);
        chk($sformatf("%s[%0d].stall_count", tag, idx), sel3 ? 64'(cnt3) : 64'(cnt1),
            64'(v.e_cnt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] A, S, O, H, N, P, Q, R, C;
        vec_t ta[$];
        vec_t tb[$];
        vec_t t;

        A = rf(11'h458, 5'd3,  5'd2,  5'd1);   // ADD X1,X2,X3
        S = rf(11'h658, 5'd6,  5'd5,  5'd4);   // SUB X4,X5,X6
        O = rf(11'h550, 5'd10, 5'd8,  5'd7);   // ORR X7,X8,X10
        H = rf(11'h458, 5'd2,  5'd9,  5'd1);   // ADD X1,X9,X2
        N = rf(11'h458, 5'd9,  5'd4,  5'd3);   // ADD X3,X4,X9
        P = rf(11'h458, 5'd2,  5'd31, 5'd1);   // ADD X1,XZR,X2
        Q = 32'hF800_0049;                     // STUR X9,[X2,#0]
        R = 32'h1400_0009;                     // B #9
        C = 32'hB400_0009;                     // CBZ X9

        //        iv instr pc     exr rd ex   fl ifr idv instr pc     cnt
        ta.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      0));
        ta.push_back(mk(1, A, 'h100,  1, 0, 0,  0, 1, 0, 0, 0,      0));
        ta.push_back(mk(1, S, 'h104,  1, 0, 0,  0, 1, 1, A, 'h100,  0));
        ta.push_back(mk(1, O, 'h108,  1, 0, 0,  0, 1, 1, S, 'h104,  0));
        ta.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 1, O, 'h108,  0));
        ta.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      0));
        ta.push_back(mk(1, H, 'h10C,  1, 0, 0,  0, 1, 0, 0, 0,      0));
        ta.push_back(mk(1, N, 'h110,  1, 1, 9,  0, 0, 0, H, 'h10C,  0));
        ta.push_back(mk(1, N, 'h110,  1, 0, 9,  0, 1, 1, H, 'h10C,  1));
        ta.push_back(mk(1, P, 'h114,  1, 1, 9,  0, 0, 0, N, 'h110,  1));
        ta.push_back(mk(1, P, 'h114,  1, 0, 9,  0, 1, 1, N, 'h110,  2));
        ta.push_back(mk(1, Q, 'h118,  1, 1, 31, 0, 1, 1, P, 'h114,  2));
        ta.push_back(mk(1, R, 'h11C,  1, 1, 9,  0, 0, 0, Q, 'h118,  2));
        ta.push_back(mk(1, R, 'h11C,  1, 0, 9,  0, 1, 1, Q, 'h118,  3));
        ta.push_back(mk(1, C, 'h120,  1, 1, 9,  0, 1, 1, R, 'h11C,  3));
        ta.push_back(mk(1, A, 'h124,  1, 1, 9,  0, 0, 0, C, 'h120,  3));
        ta.push_back(mk(1, A, 'h124,  1, 0, 9,  0, 1, 1, C, 'h120,  4));
        ta.push_back(mk(1, S, 'h128,  0, 0, 0,  0, 0, 1, A, 'h124,  4));
        ta.push_back(mk(1, S, 'h128,  0, 0, 0,  0, 0, 1, A, 'h124,  4));
        ta.push_back(mk(1, S, 'h128,  0, 0, 0,  0, 0, 1, A, 'h124,  4));
        ta.push_back(mk(1, S, 'h128,  1, 0, 0,  0, 1, 1, A, 'h124,  4));
        ta.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 1, S, 'h128,  4));
        ta.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      4));

        tb.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      0));
        tb.push_back(mk(1, H, 'h300,  1, 0, 0,  0, 1, 0, 0, 0,      0));
        tb.push_back(mk(1, A, 'h304,  1, 1, 9,  0, 0, 0, H, 'h300,  0));
        tb.push_back(mk(1, A, 'h304,  1, 0, 0,  0, 0, 0, H, 'h300,  1));
        tb.push_back(mk(1, A, 'h304,  1, 0, 0,  0, 0, 0, H, 'h300,  2));
        tb.push_back(mk(1, A, 'h304,  1, 0, 0,  0, 1, 1, H, 'h300,  3));
        tb.push_back(mk(1, S, 'h308,  1, 1, 2,  0, 0, 0, A, 'h304,  3));
        tb.push_back(mk(1, S, 'h308,  1, 0, 0,  0, 0, 0, A, 'h304,  3));
        tb.push_back(mk(1, S, 'h308,  1, 0, 0,  0, 0, 0, A, 'h304,  3));
        tb.push_back(mk(1, S, 'h308,  1, 0, 0,  0, 1, 1, A, 'h304,  3));
        tb.push_back(mk(1, O, 'h30C,  1, 1, 5,  0, 0, 0, S, 'h308,  3));
        tb.push_back(mk(1, O, 'h30C,  1, 0, 0,  1, 1, 0, S, 'h308,  3));
        tb.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      3));
        tb.push_back(mk(1, A, 'h310,  1, 0, 0,  0, 1, 0, 0, 0,      3));
        t = mk(1, O, 'h314, 1, 0, 0, 1, 1, 1, A, 'h310, 3);
        t.chk_idv = 1'b0;
        tb.push_back(t);
        tb.push_back(mk(0, 0, 0,      1, 0, 0,  0, 1, 0, 0, 0,      3));
        tb.push_back(mk(1, H, 'h320,  1, 0, 0,  0, 1, 0, 0, 0,      3));
        tb.push_back(mk(0, 0, 0,      1, 1, 9,  0, 0, 0, H, 'h320,  3));

        reset = 1'b1; if_valid = 0; if_instr = '0; if_pc = '0;
        ex_ready = 1'b1; ex_mem_read = 0; ex_rd = '0; flush = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (ta[i]) apply(ta[i], 1'b0, "s1", i);

        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        foreach (tb[i]) apply(tb[i], 1'b1, "s3", i);

        // dut3 is now in STALL with its down-counter mid-way; reset must win.
        if_valid = 0; ex_mem_read = 0; flush = 0; reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.pre_if_ready", 64'(ifr3), 64'd0);
        chk("rst_mid.pre_id_valid", 64'(idv3), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid.if_ready", 64'(ifr3), 64'd1);
        chk("rst_mid.id_valid", 64'(idv3), 64'd0);
        chk("rst_mid.id_instr", 64'(ins3), 64'd0);
        chk("rst_mid.id_pc", pc3, 64'd0);
        chk("rst_mid.stall_count", 64'(cnt3), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.idle_if_ready", 64'(ifr3), 64'd1);
        chk("rst_mid.idle_id_valid", 64'(idv3), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
